// File: rtl/tone_bank_if.sv
// -----------------------------------------------------------------------------
// tone_bank_if
//   Half-period write bus for tone_bank.
//
//   Signals:
//     wr_en    write strobe, one clk cycle per write
//     wr_ch    channel index (indices >= NUM_CH are ignored by the slave)
//     wr_data  new half-period in clk cycles
//
//   Handshake: the bus has no ready signal. The slave accepts a write on every
//   rising clk edge where wr_en=1, so the master holds wr_en high for exactly
//   one cycle per write, with wr_ch/wr_data stable across that edge.
//
//   Modports:
//     master  drives the bus (controller / testbench)
//     slave   receives the bus (tone_bank)
// -----------------------------------------------------------------------------
interface tone_bank_if #(
  parameter int DIV_W = 18
) ();
  logic             wr_en;
  logic [3:0]       wr_ch;
  logic [DIV_W-1:0] wr_data;

  modport master (output wr_en, output wr_ch, output wr_data);
  modport slave  (input  wr_en, input  wr_ch, input  wr_data);
endinterface

// File: rtl/tone_bank.sv
// -----------------------------------------------------------------------------
// tone_bank
//   Polyphonic square-wave tone generator. NUM_CH identical channels, each with
//   a programmable half-period, synchronised key gating and a phase restart on
//   every key press. A first-order sigma-delta mixer merges all channels onto a
//   single output pin.
//
//   Ports:
//     clk      system clock, all logic on rising edge
//     reset_n  asynchronous active-low reset
//     key      raw asynchronous key levels, bit i gates channel i
//     wr_bus   half-period write bus (tone_bank_if.slave)
//     speaker  per-channel square wave, straight from the tone flops
//     mix_out  sigma-delta mix of all channels (lags speaker by 2 edges)
//     active   registered OR of synchronised keys
// -----------------------------------------------------------------------------
module tone_bank #(
  parameter int NUM_CH       = 5,
  parameter int DIV_W        = 18,
  parameter int DEFAULT_HALF = 191110
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] key,
  tone_bank_if.slave        wr_bus,
  output logic [NUM_CH-1:0] speaker,
  output logic              mix_out,
  output logic              active
);

  localparam int POP_W = $clog2(NUM_CH + 1);
  localparam int ACC_W = $clog2(2 * NUM_CH);
  // One spare bit so acc + pop never wraps before the threshold compare.
  localparam int SUM_W = ACC_W + 1;

  logic [NUM_CH-1:0] r_key_m;
  logic [NUM_CH-1:0] r_key_s;
  logic              r_active;

  logic [DIV_W-1:0]  r_half [NUM_CH];
  logic [DIV_W-1:0]  r_cnt  [NUM_CH];
  logic [NUM_CH-1:0] r_tone;

  logic [POP_W-1:0]  r_pop;
  logic [ACC_W-1:0]  r_acc;
  logic              r_mix;

  logic [DIV_W-1:0]  w_lim [NUM_CH];
  logic [POP_W-1:0]  w_pop;
  logic [SUM_W-1:0]  w_sum;

  // ---------------------------------------------------------------------------
  // Key synchroniser and activity flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_key_m  <= '0;
      r_key_s  <= '0;
      r_active <= 1'b0;
    end else begin
      r_key_m  <= key;
      r_key_s  <= r_key_m;
      r_active <= |r_key_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Half-period registers. Matching against each channel's own index means an
  // out-of-range wr_ch simply matches nothing.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_half[i] <= DIV_W'(DEFAULT_HALF);
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_bus.wr_en && (wr_bus.wr_ch == 4'(i))) begin
          r_half[i] <= wr_bus.wr_data;
        end
      end
    end
  end

  // Terminal count is h_eff-1 with h_eff = max(half, 2); computed from the live
  // register so a mid-tone write takes effect on the very next compare.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_lim[i] = '0;
      if (r_half[i] < DIV_W'(2)) begin
        w_lim[i] = DIV_W'(1);
      end else begin
        w_lim[i] = r_half[i] - DIV_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Channel counters. A released key clears both counter and tone, which is
  // what gives every press the same phase.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_cnt[i] <= '0;
      end
      r_tone <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!r_key_s[i]) begin
          r_cnt[i]  <= '0;
          r_tone[i] <= 1'b0;
        end else if (r_cnt[i] >= w_lim[i]) begin
          r_cnt[i]  <= '0;
          r_tone[i] <= ~r_tone[i];
        end else begin
          r_cnt[i]  <= r_cnt[i] + DIV_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sigma-delta mixer: stage 1 registers the number of high channels, stage 2
  // accumulates it modulo NUM_CH and emits a 1 on each wrap. The accumulator
  // stays below NUM_CH, so pop=NUM_CH always wraps and pop=0 never does.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_pop = w_pop + POP_W'(r_tone[i]);
    end
  end

  assign w_sum = SUM_W'(r_acc) + SUM_W'(r_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pop <= '0;
      r_acc <= '0;
      r_mix <= 1'b0;
    end else begin
      r_pop <= w_pop;
      if (w_sum >= SUM_W'(NUM_CH)) begin
        r_acc <= ACC_W'(w_sum - SUM_W'(NUM_CH));
        r_mix <= 1'b1;
      end else begin
        r_acc <= ACC_W'(w_sum);
        r_mix <= 1'b0;
      end
    end
  end

  assign speaker = r_tone;
  assign mix_out = r_mix;
  assign active  = r_active;

endmodule

// File: tb/tb_tone_bank.sv
// -----------------------------------------------------------------------------
// tb_tone_bank
//   Directed bench for tone_bank with NUM_CH=5, DIV_W=18. DEFAULT_HALF is
//   overridden to 40 so the reset-default tone completes whole periods in a
//   short run. Edge numbering in the comments: edge 1 is the first rising edge
//   that samples the new key level.
// -----------------------------------------------------------------------------
module tb_tone_bank;

  localparam int NUM_CH  = 5;
  localparam int DIV_W   = 18;
  localparam int DEF_H   = 40;
  localparam logic [DIV_W-1:0] MAX_H = '1;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NUM_CH-1:0] key;
  logic [NUM_CH-1:0] speaker;
  logic              mix_out;
  logic              active;

  int n_pass  = 0;
  int n_total = 0;

  tone_bank_if #(.DIV_W(DIV_W)) wr_bus ();

  tone_bank #(
    .NUM_CH       (NUM_CH),
    .DIV_W        (DIV_W),
    .DEFAULT_HALF (DEF_H)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .key     (key),
    .wr_bus  (wr_bus),
    .speaker (speaker),
    .mix_out (mix_out),
    .active  (active)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Driver tasks: all driving and sampling happens 1 time unit after posedge
  // ---------------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [3:0] ch, input logic [DIV_W-1:0] data);
    wr_bus.wr_en   = 1'b1;
    wr_bus.wr_ch   = ch;
    wr_bus.wr_data = data;
    step(1);
    wr_bus.wr_en   = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset_n = 1'b0;
    key     = '1;
    step(4);
    n_total++;
    if (speaker !== 5'b00000) $display("FAIL reset_speaker got=%b exp=%b", speaker, 5'b00000);
    else n_pass++;
    n_total++;
    if (mix_out !== 1'b0) $display("FAIL reset_mix got=%b exp=0", mix_out);
    else n_pass++;
    n_total++;
    if (active !== 1'b0) $display("FAIL reset_active got=%b exp=0", active);
    else n_pass++;
    key     = '0;
    reset_n = 1'b1;
    step(4);
  endtask

  // Default half 40: rise at edge 42, fall at 82; active at edge 3.
  task automatic test_default();
    key = 5'b00001;
    step(2);
    n_total++;
    if (active !== 1'b0) $display("FAIL default_active_e2 got=%b exp=0", active);
    else n_pass++;
    step(1);
    n_total++;
    if (active !== 1'b1) $display("FAIL default_active_e3 got=%b exp=1", active);
    else n_pass++;
    step(38);
    n_total++;
    if (speaker[0] !== 1'b0) $display("FAIL default_e41 got=%b exp=0", speaker[0]);
    else n_pass++;
    step(1);
    n_total++;
    if (speaker[0] !== 1'b1) $display("FAIL default_rise_e42 got=%b exp=1", speaker[0]);
    else n_pass++;
    step(39);
    n_total++;
    if (speaker[0] !== 1'b1) $display("FAIL default_e81 got=%b exp=1", speaker[0]);
    else n_pass++;
    step(1);
    n_total++;
    if (speaker[0] !== 1'b0) $display("FAIL default_fall_e82 got=%b exp=0", speaker[0]);
    else n_pass++;
    key = 5'b00000;
    step(3);
    n_total++;
    if (active !== 1'b0) $display("FAIL default_release_active got=%b exp=0", active);
    else n_pass++;
  endtask

  // half[2]=4: rise at edge 6, fall 10, rise 14.
  task automatic test_program();
    wr(4'd2, 18'd4);
    key[2] = 1'b1;
    step(2);
    n_total++;
    if (active !== 1'b0) $display("FAIL prog_active_e2 got=%b exp=0", active);
    else n_pass++;
    step(1);
    n_total++;
    if (active !== 1'b1) $display("FAIL prog_active_e3 got=%b exp=1", active);
    else n_pass++;
    step(2);
    n_total++;
    if (speaker[2] !== 1'b0) $display("FAIL prog_e5 got=%b exp=0", speaker[2]);
    else n_pass++;
    step(1);
    n_total++;
    if (speaker[2] !== 1'b1) $display("FAIL prog_rise_e6 got=%b exp=1", speaker[2]);
    else n_pass++;
    step(3);
    n_total++;
    if (speaker[2] !== 1'b1) $display("FAIL prog_e9 got=%b exp=1", speaker[2]);
    else n_pass++;
    step(1);
    n_total++;
    if (speaker[2] !== 1'b0) $display("FAIL prog_fall_e10 got=%b exp=0", speaker[2]);
    else n_pass++;
    step(4);
    n_total++;
    if (speaker[2] !== 1'b1) $display("FAIL prog_rise_e14 got=%b exp=1", speaker[2]);
    else n_pass++;
    key[2] = 1'b0;
    step(3);
  endtask

  // half[1]=0 clamps to 2 (period 4); writes to channels 7 and 5 are dropped.
  task automatic test_clamp_ignore();
    wr(4'd1, 18'd0);
    key[1] = 1'b1;
    step(3);
    n_total++;
    if (speaker[1] !== 1'b0) $display("FAIL clamp_e3 got=%b exp=0", speaker[1]);
    else n_pass++;
    step(1);
    n_total++;
    if (speaker[1] !== 1'b1) $display("FAIL clamp_rise_e4 got=%b exp=1", speaker[1]);
    else n_pass++;
    step(2);
    n_total++;
    if (speaker[1] !== 1'b0) $display("FAIL clamp_fall_e6 got=%b exp=0", speaker[1]);
    else n_pass++;
    wr(4'd7, 18'd50);   // edge 7
    n_total++;
    if (speaker[1] !== 1'b0) $display("FAIL ignore7_e7 got=%b exp=0", speaker[1]);
    else n_pass++;
    wr(4'd5, 18'd50);   // edge 8
    n_total++;
    if (speaker[1] !== 1'b1) $display("FAIL ignore5_rise_e8 got=%b exp=1", speaker[1]);
    else n_pass++;
    step(2);
    n_total++;
    if (speaker[1] !== 1'b0) $display("FAIL ignore5_fall_e10 got=%b exp=0", speaker[1]);
    else n_pass++;
    key[1] = 1'b0;
    step(3);
    n_total++;
    if (speaker[1] !== 1'b0) $display("FAIL clamp_release got=%b exp=0", speaker[1]);
    else n_pass++;
    // Channel 2 must still hold half=4 after the dropped writes.
    key[2] = 1'b1;
    step(5);
    n_total++;
    if (speaker[2] !== 1'b0) $display("FAIL ch2_kept_e5 got=%b exp=0", speaker[2]);
    else n_pass++;
    step(1);
    n_total++;
    if (speaker[2] !== 1'b1) $display("FAIL ch2_kept_e6 got=%b exp=1", speaker[2]);
    else n_pass++;
    key[2] = 1'b0;
    step(3);
  endtask

  // half[0]=10, cnt=7 after edge 9 where half becomes 3: toggle at edge 10,
  // then every 3 edges (13, 16).
  task automatic test_midtone();
    wr(4'd0, 18'd10);
    key[0] = 1'b1;
    step(8);
    wr(4'd0, 18'd3);    // edge 9
    n_total++;
    if (speaker[0] !== 1'b0) $display("FAIL mid_e9 got=%b exp=0", speaker[0]);
    else n_pass++;
    step(1);
    n_total++;
    if (speaker[0] !== 1'b1) $display("FAIL mid_rise_e10 got=%b exp=1", speaker[0]);
    else n_pass++;
    step(2);
    n_total++;
    if (speaker[0] !== 1'b1) $display("FAIL mid_e12 got=%b exp=1", speaker[0]);
    else n_pass++;
    step(1);
    n_total++;
    if (speaker[0] !== 1'b0) $display("FAIL mid_fall_e13 got=%b exp=0", speaker[0]);
    else n_pass++;
    step(3);
    n_total++;
    if (speaker[0] !== 1'b1) $display("FAIL mid_rise_e16 got=%b exp=1", speaker[0]);
    else n_pass++;
    key[0] = 1'b0;
    step(3);
  endtask

  // half[3]=5: rise at edge 7; release during the high phase clears on the
  // third edge; re-press rises again at edge 7.
  task automatic test_release_repress();
    wr(4'd3, 18'd5);
    key[3] = 1'b1;
    step(6);
    n_total++;
    if (speaker[3] !== 1'b0) $display("FAIL rel_e6 got=%b exp=0", speaker[3]);
    else n_pass++;
    step(1);
    n_total++;
    if (speaker[3] !== 1'b1) $display("FAIL rel_rise_e7 got=%b exp=1", speaker[3]);
    else n_pass++;
    step(1);
    key[3] = 1'b0;
    step(2);
    n_total++;
    if (speaker[3] !== 1'b1) $display("FAIL rel_hold_r2 got=%b exp=1", speaker[3]);
    else n_pass++;
    step(1);
    n_total++;
    if (speaker[3] !== 1'b0) $display("FAIL rel_clear_r3 got=%b exp=0", speaker[3]);
    else n_pass++;
    key[3] = 1'b1;
    step(6);
    n_total++;
    if (speaker[3] !== 1'b0) $display("FAIL repress_e6 got=%b exp=0", speaker[3]);
    else n_pass++;
    step(1);
    n_total++;
    if (speaker[3] !== 1'b1) $display("FAIL repress_rise_e7 got=%b exp=1", speaker[3]);
    else n_pass++;
    key[3] = 1'b0;
    step(3);
  endtask

  // Channels are parked high by letting them rise on half=8, then writing the
  // maximum half before the first fall at edge 18.
  task automatic test_mixer();
    int ones;
    key = '0;
    step(6);
    wr(4'd0, 18'd8);
    wr(4'd1, 18'd8);
    key = 5'b00011;
    step(10);
    n_total++;
    if (speaker !== 5'b00011) $display("FAIL mix_two_high got=%b exp=%b", speaker, 5'b00011);
    else n_pass++;
    wr(4'd0, MAX_H);
    wr(4'd1, MAX_H);
    step(4);
    ones = 0;
    repeat (1000) begin
      step(1);
      ones += int'(mix_out);
    end
    n_total++;
    if (ones < 399 || ones > 401) $display("FAIL mix_density_2of5 got=%0d exp=400+-1", ones);
    else n_pass++;

    wr(4'd2, 18'd8);
    wr(4'd3, 18'd8);
    wr(4'd4, 18'd8);
    key = 5'b11111;
    step(10);
    n_total++;
    if (speaker !== 5'b11111) $display("FAIL mix_all_high got=%b exp=%b", speaker, 5'b11111);
    else n_pass++;
    wr(4'd2, MAX_H);
    wr(4'd3, MAX_H);
    wr(4'd4, MAX_H);
    step(3);
    ones = 0;
    repeat (200) begin
      step(1);
      ones += int'(mix_out);
    end
    n_total++;
    if (ones != 200) $display("FAIL mix_all_on got=%0d exp=200", ones);
    else n_pass++;

    key = '0;
    step(6);
    n_total++;
    if (speaker !== 5'b00000) $display("FAIL mix_all_off_spk got=%b exp=%b", speaker, 5'b00000);
    else n_pass++;
    ones = 0;
    repeat (200) begin
      step(1);
      ones += int'(mix_out);
    end
    n_total++;
    if (ones != 0) $display("FAIL mix_all_off got=%0d exp=0", ones);
    else n_pass++;
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    reset_n        = 1'b0;
    key            = '0;
    wr_bus.wr_en   = 1'b0;
    wr_bus.wr_ch   = '0;
    wr_bus.wr_data = '0;

    test_reset();
    test_default();
    test_program();
    test_clamp_ignore();
    test_midtone();
    test_release_repress();
    test_mixer();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tone_bank.md
# tone_bank

Parametrised polyphonic square-wave tone generator for the keyboard/speaker path. It replaces fixed per-note generators with NUM_CH identical channels. Each channel has a run-time programmable half-period register, synchronised key gating and a deterministic phase restart on every key press. A first-order sigma-delta mixer also merges all sounding channels onto one speaker pin, so a single-output board can play chords.

## Interface
Parameters:
- NUM_CH, 5, number of tone channels (1..16)
- DIV_W, 18, width of half-period registers and channel counters
- DEFAULT_HALF, 191110, reset value of every half-period register, in clk cycles (C4 at 100 MHz)

Ports:
- clk  in  1  system clock; one clock domain, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- key  in  NUM_CH  raw key levels (asynchronous), bit i gates channel i
- wr_en  in  1  half-period write strobe
- wr_ch  in  4  channel index for write
- wr_data  in  DIV_W  new half-period in cycles
- speaker  out  NUM_CH  per-channel square wave
- mix_out  out  1  sigma-delta mix of all channels
- active  out  1  OR of synchronised keys

## Operation
- Reset (asynchronous, while reset_n=0):
  - all outputs are 0; counters, sync flops and the accumulator are 0
  - every half-period register is DEFAULT_HALF
- Key sync: key passes through 2 flops to give key_s. active = registered OR of key_s.
- Half-period write: on a clock with wr_en=1 and wr_ch<NUM_CH, half[wr_ch] <= wr_data. wr_ch>=NUM_CH is ignored with no side effects. Effective half h_eff = max(half, 2).
- Channel i, each edge:
  - key_s[i]=0: cnt<=0, tone<=0. This is the phase restart.
  - key_s[i]=1 and cnt >= h_eff-1: cnt<=0, tone<=~tone.
  - key_s[i]=1 otherwise: cnt<=cnt+1.
  - speaker[i] = tone[i], driven directly from the flop.
- Mid-tone write: the compare uses the live register. If the new h_eff-1 <= cnt, the channel toggles on the next edge and continues at the new period. There is no glitch shorter than 1 cycle.
- Mixer:
  - stage 1: pop <= popcount(tone), range 0..NUM_CH
  - stage 2: if acc+pop >= NUM_CH, then acc <= acc+pop-NUM_CH and mix_out <= 1; else acc <= acc+pop and mix_out <= 0
  - acc width is clog2(2*NUM_CH)
  - long-run density of mix_out is pop/NUM_CH exactly; all-on gives a constant 1, all-off a constant 0
- Simultaneous events:
  - a write to a channel whose key releases in the same cycle stores the data; the channel still clears
  - a write and a toggle in the same cycle: the toggle uses the old value, later compares use the new one

## Timing
- Edge 1 is the first edge that samples key[i]=1.
  - key_s[i] is 1 after edge 2
  - cnt=1 after edge 3
  - speaker[i] rises at edge h_eff+2, then toggles every h_eff edges (period 2*h_eff)
- Release, with edge 1 sampling key[i]=0: speaker[i] is 0 after edge 3, whatever its phase.
- Re-press always restarts with the first rising edge h_eff+2 edges after sampling.
- active follows key by 3 edges (2 sync + 1 register).
- mix_out lags speaker by 2 edges.
- Write to compare: the value written at edge n is used in the compare at edge n+1.
- reset_n deassertion mid-tone: the first rising edge of speaker follows the normal press timing, counted from the first edge after release of reset.

## Test plan
- Reset defaults: hold reset_n=0 with keys high -> all outputs 0. Release reset, press key[0] with no writes -> speaker[0] period 382220 cycles, first rise 191112 edges after first sample.
- Program and play: write half[2]=4, hold key[2] -> speaker[2] rises at edge 6, then toggles every 4 edges. active=1 from edge 3.
- Minimum clamp and ignored index:
  - write half[1]=0 -> period 4 (h_eff=2)
  - write wr_ch=7 (NUM_CH=5) -> no register changes
- Mid-tone shrink: half[0]=10, cnt reaches 7, then write 3 -> toggle on next edge, then toggles every 3 edges.
- Release/re-press: release key[3] mid-high-phase -> speaker[3]=0 within 3 edges. Re-press -> first rise again h_eff+2 edges after sampling.
- Mixer: NUM_CH=5, channels 0 and 1 forced high (large half) -> over 1000 cycles mix_out ones = 400±1. All 5 high -> mix_out constant 1. None high -> constant 0.
